dice_roller: RTL and testbench
==============================

Name: dice_roller

Overview:
- Electronic die front-end feeding the board's 3-bit-code seven-segment decoder stage directly.
- Reads the raw push-button and animates a rolling face while the button is held.
- After release, the face decelerates and lands on a face sampled from a free-running counter.
- Outputs a 3-bit face code: 0 means never rolled since reset, 1..6 are die faces; no other codes are ever driven.

Parameters:
- TICK_DIV, 2_500_000: clock cycles per animation tick (20 Hz at 50 MHz); legal when ≥ 2.
- DEBOUNCE_CYCLES, 500_000: consecutive stable synchronized samples needed to accept a button level change; legal when ≥ 1.
- SETTLE_STEPS, 6: number of decelerating face steps after release; legal when ≥ 1.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- roll_btn, input, 1: raw asynchronous push-button, 1 = pressed.
- face, output, 3: 0 = blank (initial), 1..6 = die face; feeds the 7-segment decoder.
- rolling, output, 1: high in ROLLING and SETTLE.
- done, output, 1: one-cycle pulse when the final face is loaded.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-high. All registers take their reset value on a clock edge with reset=1.
- Reset values:
  - face=0, rolling=0, done=0, state=IDLE.
  - prescaler=0, seed=1, debounced level=0, sync flops=0, all step/wait counters=0.
- Synchronizer: roll_btn passes through 2 flops.
- Debounce:
  - The counter increments while the synced level differs from the debounced level, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles on that edge and the counter clears.
  - press = 1-cycle pulse on a debounced 0->1 transition; release = 1-cycle pulse on a debounced 1->0 transition.
- Prescaler:
  - Free-runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle when prescaler==TICK_DIV-1.
  - The prescaler is never cleared by the FSM.
- Seed counter:
  - Advances every clock 1,2,...,6,1,...
  - Never takes value 0 or 7.
- Face advance rule: 6 -> 1, otherwise +1.
- FSM:
  - IDLE: on press -> ROLLING, and set face=1 on the same edge.
  - ROLLING:
    - On each tick, advance face.
    - On release: capture target=seed on the same edge, set step=0 and wait=0, then go to SETTLE.
    - If tick and release coincide, both the advance and the capture happen.
  - SETTLE:
    - On each tick, wait increments.
    - When a tick arrives with wait==step, the step completes and wait clears.
    - For step < SETTLE_STEPS-1, a completing step advances face and increments step.
    - For step == SETTLE_STEPS-1, a completing step loads face=target, pulses done=1 for that one cycle, and goes to SHOW.
    - Total settle duration is SETTLE_STEPS*(SETTLE_STEPS+1)/2 ticks.
  - SHOW: face holds; on press -> ROLLING, and face advances from its current value (it does not go back to 1).
  - Presses and releases that arrive in SETTLE are ignored, with no queuing. A button still held on entry to SHOW causes no roll until it is released and pressed again.
- rolling is registered and equals (state==ROLLING or state==SETTLE) one cycle after the state transition, i.e. aligned with the state register.
- done is high only in the cycle of the SETTLE->SHOW transition output.
- Reset mid-operation (any state) returns to IDLE with face=0 on the next edge. Any target in progress is discarded.
- Press-to-rolling latency: 2 (sync) + DEBOUNCE_CYCLES + 1 (FSM) clock edges after roll_btn is stable high.

Decomposition:
- Package dice_pkg holds:
  - the state enum (IDLE, ROLLING, SETTLE, SHOW);
  - FACE_BLANK=3'd0, FACE_MIN=3'd1, FACE_MAX=3'd6;
  - a next_face function implementing the wrap rule.
- Sub-module btn_debounce (synchronizer + debounce counter) outputs the level plus press/release pulses. It is reused by other button inputs.
- The prescaler, seed counter and FSM stay in dice_roller.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, SETTLE_STEPS=3):
- Reset held for 2 cycles -> face=0, rolling=0, done=0. No outputs change during 50 idle cycles.
- Two-cycle glitch on roll_btn -> debounced level never toggles; face stays 0, rolling stays 0.
- Hold roll_btn for 40 cycles:
  - rolling rises 6 edges after roll_btn stays stable high, with face=1.
  - face then advances by 1 per tick (every 4 cycles), wrapping 6->1.
- Release after the hold:
  - the seed value at the release edge is captured;
  - face steps exactly 2 more times over 6 ticks (24 cycles ±3 for tick phase) and then equals the captured seed;
  - done pulses exactly once; rolling falls in the same cycle that state becomes SHOW.
- Press pulse during SETTLE -> no effect; the settle duration and final face are unchanged. A later press in SHOW restarts ROLLING from the current face.
- Assert reset during SETTLE -> next edge gives face=0, rolling=0, state=IDLE; done never fires. Check face ∈ {0..6} is always true for the whole run.

Source files
------------

// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, face codes and face wrap helper for the dice roller
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [2:0] FACE_BLANK = 3'd0;
    localparam logic [2:0] FACE_MIN   = 3'd1;
    localparam logic [2:0] FACE_MAX   = 3'd6;

    function automatic logic [2:0] next_face(input logic [2:0] f);
        return (f == FACE_MAX) ? FACE_MIN : f + 3'd1;
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// rtl/dice_roller_if.sv - button in, face/status out bundle for the dice roller
interface dice_roller_if;
    logic       roll_btn;
    logic [2:0] face;
    logic       rolling;
    logic       done;

    modport master (output roll_btn, input face, input rolling, input done);
    modport slave  (input roll_btn, output face, output rolling, output done);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stable-count debounce with edge pulses
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            pressed  <= 1'b0;
            released <= 1'b0;
            // Any sample that agrees with the accepted level restarts the stability count.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level    <= sync2;
                    cnt      <= '0;
                    pressed  <= sync2;
                    released <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - die face animator: roll while held, decelerate and land on a sampled face
module dice_roller #(
    parameter int TICK_DIV        = 2_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int SETTLE_STEPS    = 6
) (
    input  logic        clock,
    input  logic        reset,
    dice_roller_if.slave bus
);
    import dice_pkg::*;

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SETTLE_STEPS) + 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SETTLE_STEPS - 1);

    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    seed;
    state_t        state;
    logic [2:0]    face_q;
    logic          rolling_q;
    logic          done_q;
    logic [2:0]    target;
    logic [SW-1:0] step;
    logic [SW-1:0] wait_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .btn     (bus.roll_btn),
        .level   (btn_level),
        .pressed (press_pulse),
        .released(release_pulse)
    );

    assign tick = (presc == TICK_LAST);

    // Prescaler and seed run regardless of FSM state so the landing face depends on release timing.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
            seed  <= FACE_MIN;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            seed  <= next_face(seed);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            face_q    <= FACE_BLANK;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
            target    <= FACE_BLANK;
            step      <= '0;
            wait_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_pulse && btn_level) begin
                        state     <= ROLLING;
                        face_q    <= FACE_MIN;
                        rolling_q <= 1'b1;
                    end
                end
                ROLLING: begin
                    if (tick) begin
                        face_q <= next_face(face_q);
                    end
                    if (release_pulse) begin
                        target   <= seed;
                        step     <= '0;
                        wait_cnt <= '0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Step n lasts n+1 ticks, so the face slows down as it settles.
                    if (tick) begin
                        if (wait_cnt == step) begin
                            wait_cnt <= '0;
                            if (step == STEP_LAST) begin
                                face_q    <= target;
                                done_q    <= 1'b1;
                                rolling_q <= 1'b0;
                                state     <= SHOW;
                            end else begin
                                face_q <= next_face(face_q);
                                step   <= step + 1'b1;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (press_pulse && btn_level) begin
                        state     <= ROLLING;
                        face_q    <= next_face(face_q);
                        rolling_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.face    = face_q;
    assign bus.rolling = rolling_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - randomized and directed bench against a behavioural dice model
module tb_dice_roller;

    localparam int T = 4;
    localparam int D = 3;
    localparam int S = 3;

    localparam int M_IDLE   = 0;
    localparam int M_ROLL   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_SHOW   = 3;

    logic clock;
    logic reset;

    dice_roller_if bus ();

    dice_roller #(
        .TICK_DIV       (T),
        .DEBOUNCE_CYCLES(D),
        .SETTLE_STEPS   (S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // Model state: edge index since reset, button history, debounced level and a settle schedule.
    int k, b1, b2, lvl, streak, p_press, p_rel;
    int mode, m_face, m_roll, m_done, target, st, dsteps;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int adv(input int f);
        return (f % 6) + 1;
    endfunction

    task automatic model_edge(input logic rst, input logic btn);
        int press, rel, tick, seed;
        if (rst) begin
            k = 0; b1 = 0; b2 = 0; lvl = 0; streak = 0; p_press = 0; p_rel = 0;
            mode = M_IDLE; m_face = 0; m_roll = 0; m_done = 0; target = 0; st = 0; dsteps = 0;
            return;
        end
        k++;
        tick  = ((k % T) == 0) ? 1 : 0;
        seed  = ((k - 1) % 6) + 1;
        press = p_press;
        rel   = p_rel;
        p_press = 0;
        p_rel   = 0;
        if (b2 != lvl) begin
            streak++;
            if (streak == D) begin
                lvl = b2;
                streak = 0;
                if (lvl == 1) p_press = 1; else p_rel = 1;
            end
        end else begin
            streak = 0;
        end
        b2 = b1;
        b1 = int'(btn);
        m_done = 0;
        case (mode)
            M_IDLE: if (press == 1) begin mode = M_ROLL; m_face = 1; end
            M_ROLL: begin
                if (tick == 1) m_face = adv(m_face);
                if (rel == 1) begin target = seed; st = 0; dsteps = 0; mode = M_SETTLE; end
            end
            M_SETTLE: if (tick == 1) begin
                st++;
                // Steps finish at cumulative tick counts 1, 3, 6, ... (triangular numbers).
                if (st == (dsteps + 1) * (dsteps + 2) / 2) begin
                    dsteps++;
                    if (dsteps == S) begin
                        m_face = target; m_done = 1; mode = M_SHOW;
                    end else begin
                        m_face = adv(m_face);
                    end
                end
            end
            default: if (press == 1) begin mode = M_ROLL; m_face = adv(m_face); end
        endcase
        m_roll = (mode == M_ROLL || mode == M_SETTLE) ? 1 : 0;
    endtask

    task automatic cyc(input logic btn);
        bus.roll_btn = btn;
        @(posedge clock);
        model_edge(reset, btn);
        #1;
        check_val("face", int'(bus.face), m_face);
        check_val("rolling", int'(bus.rolling), m_roll);
        check_val("done", int'(bus.done), m_done);
        check_val("face_range", (bus.face <= 3'd6) ? 1 : 0, 1);
        if (bus.done) done_seen++;
    endtask

    task automatic run(input logic btn, input int n);
        for (int i = 0; i < n; i++) cyc(btn);
    endtask

    initial begin
        int lat;
        int d0;
        bus.roll_btn = 1'b0;
        reset = 1'b1;
        run(1'b0, 2);
        check_val("reset_face", int'(bus.face), 0);
        check_val("reset_rolling", int'(bus.rolling), 0);
        check_val("reset_done", int'(bus.done), 0);
        reset = 1'b0;
        run(1'b0, 50);

        run(1'b1, 2);
        run(1'b0, 12);
        check_val("glitch_face", int'(bus.face), 0);

        lat = 0;
        for (int i = 0; i < 20 && !bus.rolling; i++) begin
            cyc(1'b1);
            lat++;
        end
        check_val("press_latency", lat, 6);
        check_val("first_face", int'(bus.face), 1);
        run(1'b1, 40 - lat);
        d0 = done_seen;
        run(1'b0, 45);
        check_val("done_once", done_seen - d0, 1);
        check_val("settled_idle", int'(bus.rolling), 0);

        run(1'b1, 40);
        d0 = done_seen;
        run(1'b0, 10);
        run(1'b1, 6);
        run(1'b0, 40);
        check_val("settle_press_ignored", done_seen - d0, 1);
        run(1'b1, 20);
        run(1'b0, 45);

        run(1'b1, 30);
        run(1'b0, 12);
        d0 = done_seen;
        reset = 1'b1;
        cyc(1'b0);
        check_val("midreset_face", int'(bus.face), 0);
        check_val("midreset_rolling", int'(bus.rolling), 0);
        reset = 1'b0;
        run(1'b0, 40);
        check_val("midreset_no_done", done_seen - d0, 0);

        for (int r = 0; r < 25; r++) begin
            run(1'b1, int'($urandom_range(1, 40)));
            run(1'b0, int'($urandom_range(1, 50)));
        end
        run(1'b0, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
